// File: rtl/fpro_timer_pkg.sv
// Shared definitions for the FPro down-counting timer slot:
// register offsets, control/status bit positions and the control-register layout.
package fpro_timer_pkg;

  // Word offsets within the MMIO slot
  localparam int REG_CTRL     = 0;
  localparam int REG_LOAD     = 1;
  localparam int REG_PRESCALE = 2;
  localparam int REG_COUNT    = 3;
  localparam int REG_STATUS   = 4;

  // CTRL bit positions (START is write-only and never stored)
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_START = 2;

  // STATUS bit positions
  localparam int STATUS_DONE = 0;

  // Stored part of the CTRL register
  typedef struct packed {
    logic auto_reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/fpro_tick_gen.sv
// Prescaler for the timer: counts enabled cycles and emits a tick every
// (prescale+1) enabled cycles. The comparison always uses the live prescale
// value, so shrinking prescale below the current count lets pcnt run on and
// wrap before the next tick.
module fpro_tick_gen
  import fpro_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] pcnt_q;
  logic [PRESCALE_WIDTH-1:0] pcnt_d;
  logic                      match;

  assign match = (pcnt_q == prescale);
  assign tick  = en && match;

  // Next prescaler count: clear wins, otherwise advance or roll over while enabled
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      if (match) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // Prescaler count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/fpro_timer_core.sv
// FPro MMIO timer slot: register file, down-counter with expiry/auto-reload,
// sticky DONE flag, one-cycle timer_complete pulse and combinational read mux.
module fpro_timer_core
  import fpro_timer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  timer_complete
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(REG_CTRL);
  localparam logic [ADDR_WIDTH-1:0] A_LOAD     = ADDR_WIDTH'(REG_LOAD);
  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(REG_PRESCALE);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT    = ADDR_WIDTH'(REG_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(REG_STATUS);
  localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);

  // Register state
  ctrl_t                     ctrl_q,     ctrl_d;
  logic [DATA_WIDTH-1:0]     load_q,     load_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0]     count_q,    count_d;
  logic                      done_q,     done_d;
  logic                      tc_q,       tc_d;

  // Decoded bus strobes
  logic wr_en;
  logic wr_ctrl;
  logic wr_load;
  logic wr_prescale;
  logic wr_status;
  logic start;

  // Counting control
  logic run;
  logic tick;
  logic expire;

  // The read strobe carries no side effects; reads are a pure address mux
  logic unused_read;
  assign unused_read = read;

  assign wr_en       = cs && write;
  assign wr_ctrl     = wr_en && (addr == A_CTRL);
  assign wr_load     = wr_en && (addr == A_LOAD);
  assign wr_prescale = wr_en && (addr == A_PRESCALE);
  assign wr_status   = wr_en && (addr == A_STATUS);
  assign start       = wr_ctrl && wr_data[CTRL_START];

  // Counting only proceeds while enabled and there is something left to count
  assign run    = ctrl_q.en && (count_q != '0);
  // A START in the same cycle overrides any tick, so no expiry can coincide with it
  assign expire = tick && !start && (count_q == ONE);

  fpro_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .clr      (start),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Configuration register writes; LOAD and PRESCALE take effect on the count only at START/reload
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    prescale_d = prescale_q;
    if (wr_ctrl) begin
      ctrl_d.en          = wr_data[CTRL_EN];
      ctrl_d.auto_reload = wr_data[CTRL_AUTO];
    end
    if (wr_load) begin
      load_d = wr_data;
    end
    if (wr_prescale) begin
      prescale_d = wr_data[PRESCALE_WIDTH-1:0];
    end
  end

  // Down-counter: START reload has priority over tick-driven decrement/expiry
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = load_q;
    end else if (tick) begin
      if (count_q == ONE) begin
        count_d = ctrl_q.auto_reload ? load_q : '0;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // Sticky DONE (set beats write-1-to-clear) and the single-cycle completion pulse
  always_comb begin
    done_d = done_q;
    tc_d   = expire;
    if (expire) begin
      done_d = 1'b1;
    end else if (wr_status && wr_data[STATUS_DONE]) begin
      done_d = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
    end
  end

  assign timer_complete = tc_q;

  // Combinational read mux; undefined offsets and unused bits read as zero
  always_comb begin
    rd_data = '0;
    case (addr)
      A_CTRL: begin
        rd_data[CTRL_EN]   = ctrl_q.en;
        rd_data[CTRL_AUTO] = ctrl_q.auto_reload;
      end
      A_LOAD:     rd_data = load_q;
      A_PRESCALE: rd_data[PRESCALE_WIDTH-1:0] = prescale_q;
      A_COUNT:    rd_data = count_q;
      A_STATUS:   rd_data[STATUS_DONE] = done_q;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_fpro_timer_core.sv
// Directed bench for fpro_timer_core: one task per scenario, inline checks,
// expected values worked out by hand from the register/timing behaviour.
module tb_fpro_timer_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        timer_complete;

  int n_vec = 0;
  int n_bad = 0;
  int tc_count = 0;

  fpro_timer_core #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cs             (cs),
    .read           (read),
    .write          (write),
    .addr           (addr),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .timer_complete (timer_complete)
  );

  always #5 clk = ~clk;

  // Count completion pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (timer_complete) tc_count++;
  end

  // Drive one write, sampled at the next rising edge; returns 1ns after that edge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  // Combinational read of one offset (no clock edge consumed)
  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1;
    d = rd_data;
    read = 1'b0; cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(5'(a), d);
      n_vec++;
      if (d !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_read[%0d]: got %h expected %h", a, d, 32'd0);
      end
    end
    n_vec++;
    if (timer_complete !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tc: got %b expected 0", timer_complete);
    end
    $display("test_reset: read offsets 0..7 after reset");
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int tc0;
    bus_write(5'd1, 32'd5);
    bus_write(5'd2, 32'd0);
    bus_write(5'd0, 32'b101);       // START edge t0
    tc0 = tc_count;
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd5) begin
      n_bad++;
      $display("FAIL oneshot_count_t0: got %0d expected 5", d);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus_read(5'd3, d);
      n_vec++;
      if (d !== 32'(5 - k)) begin
        n_bad++;
        $display("FAIL oneshot_count[t0+%0d]: got %0d expected %0d", k, d, 5 - k);
      end
      n_vec++;
      if (timer_complete !== (k == 5)) begin
        n_bad++;
        $display("FAIL oneshot_tc[t0+%0d]: got %b expected %b", k, timer_complete, (k == 5));
      end
    end
    repeat (4) @(posedge clk);
    #1;
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd1) begin
      n_bad++;
      $display("FAIL oneshot_status_hold: got %h expected 1", d);
    end
    n_vec++;
    if (tc_count - tc0 !== 1) begin
      n_bad++;
      $display("FAIL oneshot_pulses: got %0d expected 1", tc_count - tc0);
    end
    bus_read(5'd0, d);
    n_vec++;
    if (d !== 32'd1) begin
      n_bad++;
      $display("FAIL oneshot_ctrl_read: got %h expected 1 (START reads 0)", d);
    end
    bus_write(5'd4, 32'd1);
    $display("test_oneshot: LOAD=5 PRESCALE=0 single expiry");
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    bus_write(5'd1, 32'd3);
    bus_write(5'd2, 32'd2);
    bus_write(5'd0, 32'b111);       // START edge t0
    for (int p = 0; p < 4; p++) begin
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        n_vec++;
        if (timer_complete !== (k == 9)) begin
          n_bad++;
          $display("FAIL auto_tc[period %0d, +%0d]: got %b expected %b", p, k, timer_complete, (k == 9));
        end
      end
      bus_read(5'd3, d);
      n_vec++;
      if (d !== 32'd3) begin
        n_bad++;
        $display("FAIL auto_reload_count[period %0d]: got %0d expected 3", p, d);
      end
    end
    bus_write(5'd0, 32'd0);
    bus_write(5'd4, 32'd1);
    $display("test_auto_reload: LOAD=3 PRESCALE=2 four 9-cycle periods");
  endtask

  task automatic test_pause();
    logic [31:0] d;
    bus_write(5'd1, 32'd10);
    bus_write(5'd2, 32'd0);
    bus_write(5'd0, 32'b101);       // START edge t0
    repeat (3) @(posedge clk);
    bus_write(5'd0, 32'b000);       // EN=0 sampled at t0+4, count lands on 6
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd6) begin
      n_bad++;
      $display("FAIL pause_count_entry: got %0d expected 6", d);
    end
    repeat (20) @(posedge clk);
    #1;
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd6) begin
      n_bad++;
      $display("FAIL pause_count_held: got %0d expected 6", d);
    end
    bus_write(5'd0, 32'b001);       // resume
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      bus_read(5'd3, d);
      n_vec++;
      if (d !== 32'(6 - k)) begin
        n_bad++;
        $display("FAIL pause_resume_count[+%0d]: got %0d expected %0d", k, d, 6 - k);
      end
      n_vec++;
      if (timer_complete !== (k == 6)) begin
        n_bad++;
        $display("FAIL pause_resume_tc[+%0d]: got %b expected %b", k, timer_complete, (k == 6));
      end
    end
    $display("test_pause: hold at 6 for 20 cycles then resume");
  endtask

  task automatic test_clear_race();
    logic [31:0] d;
    bus_write(5'd4, 32'd1);
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL race_precleared: got %h expected 0", d);
    end
    bus_write(5'd1, 32'd3);
    bus_write(5'd0, 32'b101);       // START edge t0, expiry at t0+3
    repeat (2) @(posedge clk);
    bus_write(5'd4, 32'd1);         // clear sampled at the expiry edge
    n_vec++;
    if (timer_complete !== 1'b1) begin
      n_bad++;
      $display("FAIL race_tc: got %b expected 1", timer_complete);
    end
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd1) begin
      n_bad++;
      $display("FAIL race_done_set_wins: got %h expected 1", d);
    end
    bus_write(5'd4, 32'd1);
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL race_done_cleared: got %h expected 0", d);
    end
    $display("test_clear_race: STATUS clear coincident with expiry");
  endtask

  task automatic test_start_race();
    logic [31:0] d;
    bus_write(5'd1, 32'd4);
    bus_write(5'd0, 32'b101);       // START edge t0
    @(posedge clk);
    bus_write(5'd0, 32'b101);       // re-START coincides with tick at t0+2
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd4) begin
      n_bad++;
      $display("FAIL start_beats_tick: got %0d expected 4", d);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (timer_complete !== (k == 4)) begin
        n_bad++;
        $display("FAIL start_race_tc[+%0d]: got %b expected %b", k, timer_complete, (k == 4));
      end
    end
    bus_write(5'd4, 32'd1);
    $display("test_start_race: START overrides a tick");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int tc0;
    bus_write(5'd1, 32'd10);
    bus_write(5'd0, 32'b101);       // START edge t0
    repeat (6) @(posedge clk);
    #1;
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd4) begin
      n_bad++;
      $display("FAIL reset_mid_precount: got %0d expected 4", d);
    end
    tc0 = tc_count;
    @(negedge clk);
    reset = 1'b1;
    #1;
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_count: got %0d expected 0", d);
    end
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_done: got %h expected 0", d);
    end
    bus_read(5'd0, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_ctrl: got %h expected 0", d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (tc_count - tc0 !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", tc_count - tc0);
    end
    bus_read(5'd1, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_load: got %0d expected 0", d);
    end
    $display("test_reset_mid: reset at COUNT=4");
  endtask

  task automatic test_load_zero();
    logic [31:0] d;
    int tc0;
    bus_write(5'd1, 32'd0);
    bus_write(5'd0, 32'b101);
    tc0 = tc_count;
    repeat (50) @(posedge clk);
    #1;
    n_vec++;
    if (tc_count - tc0 !== 0) begin
      n_bad++;
      $display("FAIL load_zero_pulses: got %0d expected 0", tc_count - tc0);
    end
    bus_read(5'd3, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL load_zero_count: got %0d expected 0", d);
    end
    bus_read(5'd4, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL load_zero_done: got %h expected 0", d);
    end
    $display("test_load_zero: START with LOAD=0 stays idle for 50 cycles");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_pause();
    test_clear_race();
    test_start_race();
    test_reset_mid();
    test_load_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fpro_timer_core.md
Name: fpro_timer_core

Overview:
Programmable down-counting timer. It is the responder on one FPro MMIO slot, so it is the far end of the bridge/MMIO bus.
- Bus writes from the processor configure a reload value, a prescaler and the control bits.
- The core counts autonomously and asserts a sticky done flag plus a one-cycle timer_complete pulse on expiry.
- The pulse goes to a top-level pin and to interrupt logic.

Parameters:
ADDR_WIDTH, 5, slot word-address width (fixed by the MMIO slot decoder)
DATA_WIDTH, 32, bus data width and counter width
PRESCALE_WIDTH, 16, prescaler register width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cs  input  1  slot select from the MMIO decoder
read  input  1  read strobe, qualified by cs
write  input  1  write strobe, qualified by cs
addr  input  ADDR_WIDTH  word register offset within the slot
wr_data  input  DATA_WIDTH  write data
rd_data  output  DATA_WIDTH  read data (combinational mux on addr)
timer_complete  output  1  one-cycle pulse on expiry (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Reset clears all registers: ctrl, load, prescale, count, pcnt, done and timer_complete. rd_data follows the cleared state.
- Register map (word offsets):
  - 0 CTRL (R/W): bit0 EN, bit1 AUTO_RELOAD; bit2 START is write-only, self-clearing and always reads 0.
  - 1 LOAD (R/W): 32-bit reload value.
  - 2 PRESCALE (R/W): low PRESCALE_WIDTH bits.
  - 3 COUNT: read-only; writes are ignored.
  - 4 STATUS: bit0 DONE; write 1 to clear.
  - Offsets 5..31: read 0, writes ignored.
- Write enable is cs && write. Writes take effect at the clock edge where the strobe is sampled.
- Read is combinational: rd_data = mux(addr). Unused bits are 0. The read strobe has no side effects.
- START write (CTRL write with bit2=1): count <= LOAD and pcnt <= 0 at that edge. The same write also updates EN and AUTO_RELOAD. The LOAD value used is the registered value before this edge.
- Prescaler: when EN=1 and count!=0, pcnt increments each cycle. When pcnt==PRESCALE, this is a tick: pcnt <= 0.
- Decrement: on a tick, count <= count-1.
- Tick period: one tick every PRESCALE+1 cycles. PRESCALE=0 gives a tick every cycle.
- Expiry, on a tick with count==1:
  - done <= 1 and timer_complete <= 1 for exactly one cycle.
  - If AUTO_RELOAD=1, count <= LOAD and counting continues. Otherwise count <= 0 and the timer is idle.
- Latency: if START is sampled at edge t0 with LOAD=N>0, done and timer_complete become visible after edge t0+N*(PRESCALE+1).
- LOAD=0 at START: count stays 0, no ticks, no done.
- EN=0: pcnt and count hold (pause). Setting EN=1 again resumes from the held values.
- LOAD or PRESCALE written while counting: no effect on count until the next START or auto-reload. A PRESCALE change does apply to the pcnt comparison immediately.
- If PRESCALE is reduced below the current pcnt, pcnt runs on and wraps at 2^PRESCALE_WIDTH before the next tick. This is documented behaviour and is not corrected.
- Simultaneous events:
  - STATUS clear in the same cycle as expiry: set wins, DONE=1.
  - START in the same cycle as a tick: START wins. Count is reloaded and no decrement or expiry occurs that cycle.
- Counter arithmetic is unsigned DATA_WIDTH bits. Count never wraps below 0.
- Reset mid-count: immediate return to all-zero. No timer_complete is emitted.

Decomposition:
- Package fpro_timer_pkg holds:
  - register offset localparams (REG_CTRL=0, REG_LOAD=1, REG_PRESCALE=2, REG_COUNT=3, REG_STATUS=4);
  - CTRL bit indices (CTRL_EN=0, CTRL_AUTO=1, CTRL_START=2);
  - STATUS_DONE=0.
- Sub-module fpro_tick_gen holds pcnt and the comparison. Its ports are clk, reset, en, clr, prescale and tick.
- The top level holds the register file, the count/expiry logic and the read mux.

Test Plan:
- Reset then read all offsets 0..7 -> all read 0; timer_complete=0.
- Write LOAD=5, PRESCALE=0, CTRL=0b101 -> COUNT reads 5,4,3,2,1,0 on successive cycles. timer_complete pulses once, 5 cycles after the START edge. STATUS reads 1 and holds.
- Write LOAD=3, PRESCALE=2, CTRL=0b111 (auto-reload) -> timer_complete pulses every 9 cycles for at least 4 periods. COUNT reloads to 3 after each pulse.
- Start with LOAD=10, PRESCALE=0. Write EN=0 at COUNT=6 and hold 20 cycles -> COUNT stays 6. Set EN=1 -> expiry 6 cycles later.
- Write STATUS=1 in the same cycle as the expiry tick -> DONE reads 1. Write STATUS=1 again -> DONE reads 0.
- Assert reset while COUNT=4 -> COUNT=0 and DONE=0 on the next read; no timer_complete pulse. START with LOAD=0 -> no pulse for 50 cycles.
